// File: rtl/store_write_queue_pkg.sv
// Shared definitions for the store write queue.
//   SRC_GPR / SRC_XMM : legal write-source encodings on st_src
//   state_e           : drain sequencer states
//   entry_t           : one queued store {addr, data}
// The entry address field is EntryAddrW wide; the top-level ADDR_W must not exceed it.
package store_write_queue_pkg;

   localparam logic [1:0] SRC_GPR = 2'b01;
   localparam logic [1:0] SRC_XMM = 2'b10;

   localparam int unsigned EntryAddrW = 32;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_e;

   typedef struct packed {
      logic [EntryAddrW-1:0] addr;
      logic [31:0]           data;
   } entry_t;

endpackage

// File: rtl/store_write_queue_memory_write_mux.sv
// Memory write-source mux (MemoryWriteMux) on the store enqueue path.
// Purely combinational.
//   src      : write source select (SRC_GPR / SRC_XMM, others illegal)
//   rs2_data : general register data, passed through for SRC_GPR
//   xs2_data : XMM data, signed fixed point with 15 fraction bits, converted to fp32
//   src_ok   : src is a legal encoding
//   wr_data  : resolved 32-bit write data (zero for an illegal source)
module store_write_queue_memory_write_mux
   import store_write_queue_pkg::*;
(
   input  logic [1:0]  src,
   input  logic [31:0] rs2_data,
   input  logic [63:0] xs2_data,
   output logic        src_ok,
   output logic [31:0] wr_data
);

   logic [63:0] mag;
   logic [5:0]  msb;
   logic        nonzero;
   logic [7:0]  exp_field;
   logic [22:0] mant;
   logic [31:0] xmm_fp32;

   // Fixed point to fp32: value = xs2 / 2^15, so exponent = msb - 15 + 127.
   // Every 64-bit magnitude lands in the normal fp32 range; mantissa is truncated.
   always_comb begin
      mag     = xs2_data[63] ? (~xs2_data + 64'd1) : xs2_data;
      msb     = '0;
      nonzero = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (mag[i]) begin
            msb     = 6'(i);
            nonzero = 1'b1;
         end
      end
      exp_field = {2'b00, msb} + 8'd112;
      mant      = 23'((mag << (6'd63 - msb)) >> 40);
      xmm_fp32  = nonzero ? {xs2_data[63], exp_field, mant} : 32'd0;
   end

   always_comb begin
      src_ok  = 1'b1;
      wr_data = '0;
      case (src)
         SRC_GPR: wr_data = rs2_data;
         SRC_XMM: wr_data = xmm_fp32;
         default: src_ok  = 1'b0;
      endcase
   end

endmodule

// File: rtl/store_write_queue.sv
// Buffered store sequencer in front of the data-memory write port.
// Stores are resolved through the write-source mux at enqueue and held in a DEPTH-entry
// FIFO that drains to memory over a hold-until-ack handshake, with a fence/drain sequencer.
//   clk, rst_n              : clock, asynchronous active-low reset
//   st_valid/st_ready       : store request handshake (st_ready registered)
//   st_src/st_addr/st_rs2_data/st_xs2_data : store source select, address and data
//   st_err                  : one-cycle pulse after an illegal-source store is dropped
//   mem_wr_en/addr/data/ack : head-of-queue write request, held until ack
//   drain_req/drain_done    : level fence request, completion pulse
//   empty                   : queue holds no entries
//   ld_addr/ld_fwd_hit/ld_fwd_data : store-to-load forwarding lookup
// Optional: define STORE_WRITE_QUEUE_FWD_EN to build the ld_* ports and forwarding logic.
module store_write_queue
   import store_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [1:0]        st_src,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_rs2_data,
   input  logic [63:0]       st_xs2_data,
   output logic              st_err,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   input  logic              mem_wr_ack,
   input  logic              drain_req,
   output logic              drain_done,
   output logic              empty
`ifdef STORE_WRITE_QUEUE_FWD_EN
   ,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_fwd_hit,
   output logic [31:0]       ld_fwd_data
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   entry_t           storage_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   state_e           state_q, state_d;
   logic             st_ready_q, st_ready_d;
   logic             st_err_q, st_err_d;
   logic             drain_done_q, drain_done_d;
   logic             full_d;
   logic             accept, push, pop;
   logic             src_ok;
   logic [31:0]      mux_data;
   entry_t           head;

   store_write_queue_memory_write_mux u_memory_write_mux (
      .src      (st_src),
      .rs2_data (st_rs2_data),
      .xs2_data (st_xs2_data),
      .src_ok   (src_ok),
      .wr_data  (mux_data)
   );

   assign wr_idx = wr_ptr_q[IDX_W-1:0];
   assign rd_idx = rd_ptr_q[IDX_W-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign head   = storage_q[rd_idx];

   assign accept = st_valid && st_ready_q;
   assign push   = accept && src_ok;
   assign pop    = mem_wr_ack && !empty;

   always_comb begin
      wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      full_d   = (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]) &&
                 (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
      st_err_d = accept && !src_ok;
   end

   // Drain sequencer; the exit test uses the current empty flag, so a drain that
   // starts on an already-empty queue completes one cycle after entering DRAIN.
   always_comb begin
      state_d      = state_q;
      drain_done_d = 1'b0;
      case (state_q)
         RUN: begin
            if (drain_req) state_d = DRAIN;
         end
         DRAIN: begin
            if (empty) begin
               state_d      = RUN;
               drain_done_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Registered ready derived from next-state, so it always equals !full && RUN
   // for the current cycle and never sees a same-cycle pop.
   assign st_ready_d = !full_d && (state_d == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         state_q      <= RUN;
         st_ready_q   <= 1'b1;
         st_err_q     <= 1'b0;
         drain_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         state_q      <= state_d;
         st_ready_q   <= st_ready_d;
         st_err_q     <= st_err_d;
         drain_done_q <= drain_done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage_q[i] <= '0;
         end
      end else if (push) begin
         storage_q[wr_idx] <= '{addr: EntryAddrW'(st_addr), data: mux_data};
      end
   end

   assign st_ready    = st_ready_q;
   assign st_err      = st_err_q;
   assign drain_done  = drain_done_q;
   assign mem_wr_en   = !empty;
   assign mem_wr_addr = head.addr[ADDR_W-1:0];
   assign mem_wr_data = head.data;

`ifdef STORE_WRITE_QUEUE_FWD_EN
   logic [PTR_W-1:0] count;
   logic [IDX_W-1:0] fwd_idx;

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      ld_fwd_hit  = 1'b0;
      ld_fwd_data = '0;
      fwd_idx     = '0;
      count       = wr_ptr_q - rd_ptr_q;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_idx + IDX_W'(k);
         if ((PTR_W'(k) < count) && (storage_q[fwd_idx].addr == EntryAddrW'(ld_addr))) begin
            ld_fwd_hit  = 1'b1;
            ld_fwd_data = storage_q[fwd_idx].data;
         end
      end
   end
`endif

endmodule

// File: doc/store_write_queue.md
# store_write_queue

Buffered store sequencer in front of the data-memory write port. It accepts store requests from the execute stage, resolves write data through the existing general/XMM write-source mux at enqueue, and holds the results in a DEPTH-entry FIFO. It drains that FIFO to memory over a hold-until-ack handshake, and it supports a fence/drain operation. With forwarding compiled in, it also supplies store-to-load forwarding to the load path.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; a power of two ≥ 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request present.
- st_ready  out  1  queue can accept a store this cycle.
- st_src  in  2  write source: 2'b01 = general register, 2'b10 = XMM (Q15 converted to fp32).
- st_addr  in  ADDR_W  word-aligned store address.
- st_rs2_data  in  32  general register data.
- st_xs2_data  in  64  XMM register data, Q15.
- st_err  out  1  one-cycle pulse when a store with an illegal source was accepted and dropped.
- mem_wr_en  out  1  write request to memory.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  32  write data.
- mem_wr_ack  in  1  memory accepted the write on this edge.
- drain_req  in  1  fence; level-sensitive.
- drain_done  out  1  one-cycle pulse when a drain completes.
- empty  out  1  queue is empty.
- ld_addr  in  ADDR_W  load lookup address; present only with forwarding enabled.
- ld_fwd_hit  out  1  load address matches a queued store; present only with forwarding enabled.
- ld_fwd_data  out  32  data of the youngest matching store; present only with forwarding enabled.

## Operation
- An enqueue occurs when st_valid && st_ready at a rising edge.
  - For st_src 01 or 10, the entry {addr, data} is written at the tail. Data is rs2 for 01, or the fp32 conversion of xs2 for 10.
  - For st_src 00 or 11, nothing is written; st_err pulses on the next cycle.
- The head entry drives mem_wr_addr and mem_wr_data, with mem_wr_en = !empty.
  - The outputs stay stable until mem_wr_ack is sampled high.
  - On that edge the head pops.
  - mem_wr_ack while empty is ignored.
- Pointers are log2(DEPTH)+1 bits.
  - Full = MSBs differ and the index bits are equal.
  - Empty = pointers are equal.
  - Pointers wrap naturally.
- st_ready = !full && state == RUN. A pop in the same cycle does not raise st_ready.
- A simultaneous push and pop when neither full nor empty leaves the count unchanged.
- State machine:
  - RUN → DRAIN when drain_req=1.
  - DRAIN: st_ready=0. Leave DRAIN when empty: pulse drain_done and return to RUN.
  - drain_req asserted while already empty still gives RUN → DRAIN → RUN, with drain_done one cycle after entry to DRAIN.
  - drain_req is ignored while in DRAIN.
- Reset mid-operation discards all queued entries without issuing memory writes.

## Timing
- Reset values:
  - st_ready=1, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0.
  - st_err=0, drain_done=0, empty=1, ld_fwd_hit=0, ld_fwd_data=0.
  - State = RUN.
- Enqueue-to-mem_wr_en latency: 1 cycle into an empty queue.
- Throughput: one write per cycle when mem_wr_ack is held high.
- st_ready and mem_wr_* are registered. The st_src decode and Q15 conversion are combinational on the enqueue path.
- ld_fwd_* are combinational from ld_addr and the queue contents, valid in the same cycle. An entry popping on the current edge still counts as a hit in that cycle.

## Configuration
- STORE_WRITE_QUEUE_FWD_EN defined:
  - The ld_* ports exist.
  - ld_fwd_hit=1 when any valid entry matches ld_addr; ld_fwd_data comes from the youngest match.
  - A store being enqueued in the same cycle is not visible.
- Undefined:
  - The ld_* ports are absent.
  - No comparators are built.

## Structure
- Shared package holds:
  - Write-source constants: SRC_GPR=2'b01, SRC_XMM=2'b10.
  - The state enum {RUN, DRAIN}.
  - The entry struct {addr, data}.
- Sub-module: MemoryWriteMux is instantiated once on the enqueue path to produce entry data. The queue itself stays in this block.

## Test plan
- Enqueue GPR store at 0x100 with rs2=0xDEADBEEF, mem_wr_ack tied high → next cycle mem_wr_en=1, addr 0x100, data 0xDEADBEEF; empty=1 after the ack edge.
- Enqueue XMM store with xs2=Q15 1.0 → mem_wr_data=0x3F800000.
- Hold mem_wr_ack=0 and push 5 stores → st_ready=0 after the 4th. Release the ack → four writes in order, address/data stable while un-acked.
- Store with st_src=2'b11 → no write, st_err=1 for exactly one cycle, empty stays 1.
- Queue 2 stores, assert drain_req → st_ready=0 until both are acked; drain_done pulses once; back to RUN with st_ready=1.
- (FWD) Stores to 0x40 of 1 then 2, ld_addr=0x40 → hit=1, data=2. Assert rst_n=0 mid-queue → empty=1 and mem_wr_en=0 immediately.
